// File: rtl/bp_mem_rr_arbiter.sv
// Round-robin command arbiter in front of a single memory port, with per-requester
// outstanding-credit counters and id-routed response return.

module bp_mem_rr_arbiter_lane #(
  parameter int max_out_p = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req_v_i,
  input  logic       grant_i,
  input  logic       dec_i,
  output logic       elig_o,
  output logic       cnt_nz_o
);
  logic [2:0] cnt;

  // Simultaneous grant and response leave the count unchanged.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                                         cnt <= '0;
    else if (grant_i && !dec_i && cnt < 3'(max_out_p))   cnt <= cnt + 3'd1;
    else if (dec_i && !grant_i && cnt != '0)             cnt <= cnt - 3'd1;
  end

  assign elig_o   = req_v_i && (cnt < 3'(max_out_p));
  assign cnt_nz_o = |cnt;
endmodule

module bp_mem_rr_arbiter #(
  parameter int num_req_p   = 3,
  parameter int msg_width_p = 128,
  parameter int max_out_p   = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]            req_cmd_v_i,
  output logic [num_req_p-1:0]            req_cmd_yumi_o,
  output logic [msg_width_p-1:0]          mem_cmd_o,
  output logic                            mem_cmd_v_o,
  input  logic                            mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]          mem_resp_i,
  input  logic [2:0]                      mem_resp_id_i,
  input  logic                            mem_resp_v_i,
  output logic                            mem_resp_yumi_o,
  output logic [msg_width_p-1:0]          req_resp_o,
  output logic [num_req_p-1:0]            req_resp_v_o,
  input  logic [num_req_p-1:0]            req_resp_yumi_i,
  output logic                            error_o,
  output logic                            idle_o
);
  logic [num_req_p-1:0][msg_width_p-1:0] cmd_arr;
  logic [num_req_p-1:0] elig, cnt_nz, dec;
  logic                 buf_v;
  logic [msg_width_p-1:0] buf_msg;
  logic [2:0]           ptr;
  logic                 grant_en, win_v, grant, multi_hot;
  logic [2:0]           win_id;
  logic [msg_width_p-1:0] win_msg;
  logic                 sel_nz, sel_yumi, id_in_range, resp_ok, bad_resp;

  assign cmd_arr = req_cmd_i;

  for (genvar i = 0; i < num_req_p; i++) begin : g_lane
    bp_mem_rr_arbiter_lane #(.max_out_p(max_out_p)) u_lane (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .req_v_i  (req_cmd_v_i[i]),
      .grant_i  (req_cmd_yumi_o[i]),
      .dec_i    (dec[i]),
      .elig_o   (elig[i]),
      .cnt_nz_o (cnt_nz[i])
    );
  end

  assign grant_en = !buf_v || mem_cmd_ready_i;

  // Scan starts at ptr and wraps; the first eligible lane wins.
  always_comb begin
    win_v   = 1'b0;
    win_id  = '0;
    win_msg = '0;
    for (int k = 0; k < num_req_p; k++) begin
      automatic int idx = int'(ptr) + k;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!win_v && elig[idx]) begin
        win_v   = 1'b1;
        win_id  = 3'(idx);
        win_msg = cmd_arr[idx];
      end
    end
  end

  assign grant = !reset_i && grant_en && win_v;

  always_comb begin
    req_cmd_yumi_o = '0;
    for (int i = 0; i < num_req_p; i++)
      req_cmd_yumi_o[i] = grant && (win_id == 3'(i));
  end
  assign multi_hot = ($countones(req_cmd_yumi_o) > 1);

  // Response routing: out-of-range ids or ids with nothing outstanding are dropped.
  always_comb begin
    sel_nz   = 1'b0;
    sel_yumi = 1'b0;
    for (int i = 0; i < num_req_p; i++)
      if (mem_resp_id_i == 3'(i)) begin
        sel_nz   = cnt_nz[i];
        sel_yumi = req_resp_yumi_i[i];
      end
  end
  assign id_in_range = ({1'b0, mem_resp_id_i} < 4'(num_req_p));
  assign resp_ok     = id_in_range && sel_nz;
  assign bad_resp    = !reset_i && mem_resp_v_i && !resp_ok;

  always_comb begin
    req_resp_v_o = '0;
    for (int i = 0; i < num_req_p; i++)
      req_resp_v_o[i] = !reset_i && mem_resp_v_i && resp_ok && (mem_resp_id_i == 3'(i));
  end
  assign dec             = req_resp_v_o & req_resp_yumi_i;
  assign mem_resp_yumi_o = !reset_i && mem_resp_v_i && (resp_ok ? sel_yumi : 1'b1);
  assign req_resp_o      = mem_resp_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      buf_v   <= 1'b0;
      buf_msg <= '0;
      ptr     <= '0;
      error_o <= 1'b0;
    end else begin
      if (grant) begin
        buf_v   <= 1'b1;
        buf_msg <= win_msg;
        ptr     <= (win_id == 3'(num_req_p - 1)) ? 3'd0 : win_id + 3'd1;
      end else if (buf_v && mem_cmd_ready_i) begin
        buf_v <= 1'b0;
      end
      if (bad_resp || multi_hot) error_o <= 1'b1;
    end
  end

  assign mem_cmd_o   = buf_msg;
  assign mem_cmd_v_o = buf_v;
  assign idle_o      = !buf_v && !(|cnt_nz);

  a_yumi_onehot: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(req_cmd_yumi_o));
endmodule

// File: tb/tb_bp_mem_rr_arbiter.sv
// Directed bench for bp_mem_rr_arbiter: fairness, credits, backpressure, response
// accounting, invalid responses and mid-operation reset.

module tb_bp_mem_rr_arbiter;
  localparam int N = 3;
  localparam int W = 16;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [N*W-1:0]   req_cmd_i;
  logic [N-1:0]     req_cmd_v_i, req_cmd_yumi_o;
  logic [W-1:0]     mem_cmd_o;
  logic             mem_cmd_v_o, mem_cmd_ready_i;
  logic [W-1:0]     mem_resp_i;
  logic [2:0]       mem_resp_id_i;
  logic             mem_resp_v_i, mem_resp_yumi_o;
  logic [W-1:0]     req_resp_o;
  logic [N-1:0]     req_resp_v_o, req_resp_yumi_i;
  logic             error_o, idle_o;

  int n_tests = 0;
  int n_fail  = 0;

  bp_mem_rr_arbiter #(.num_req_p(N), .msg_width_p(W), .max_out_p(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_cmd_i(req_cmd_i), .req_cmd_v_i(req_cmd_v_i), .req_cmd_yumi_o(req_cmd_yumi_o),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_id_i(mem_resp_id_i), .mem_resp_v_i(mem_resp_v_i),
    .mem_resp_yumi_o(mem_resp_yumi_o),
    .req_resp_o(req_resp_o), .req_resp_v_o(req_resp_v_o), .req_resp_yumi_i(req_resp_yumi_i),
    .error_o(error_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_inputs();
    req_cmd_v_i     = '0;
    mem_cmd_ready_i = 1'b1;
    mem_resp_v_i    = 1'b0;
    mem_resp_id_i   = '0;
    mem_resp_i      = 16'h5A5A;
    req_resp_yumi_i = '0;
  endtask

  task automatic do_reset();
    clr_inputs();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  initial begin
    req_cmd_i = {16'hA002, 16'hA001, 16'hA000};
    clr_inputs();
    reset_i = 1'b1;
    #2;
    chk("rst_idle", idle_o, 1'b1);
    chk("rst_cmd_v", mem_cmd_v_o, 1'b0);
    chk("rst_err", error_o, 1'b0);
    tick();
    reset_i = 1'b0;

    // Round-robin: all valid, each command's response returned the next cycle.
    req_cmd_v_i = 3'b111;
    req_resp_yumi_i = 3'b111;
    for (int k = 0; k < 6; k++) begin
      mem_resp_v_i  = (k > 0);
      mem_resp_id_i = 3'((k + 2) % 3);
      #1;
      chk($sformatf("rr_yumi%0d", k), req_cmd_yumi_o, 3'b001 << (k % 3));
      chk($sformatf("rr_cmdv%0d", k), mem_cmd_v_o, (k > 0));
      if (k > 0) begin
        chk($sformatf("rr_msg%0d", k), mem_cmd_o, 16'hA000 + 16'((k - 1) % 3));
        chk($sformatf("rr_rspv%0d", k), req_resp_v_o, 3'b001 << ((k - 1) % 3));
        chk($sformatf("rr_rspy%0d", k), mem_resp_yumi_o, 1'b1);
      end
      tick();
    end
    req_cmd_v_i = '0;
    mem_resp_v_i = 1'b1;
    mem_resp_id_i = 3'd2;
    #1;
    chk("rr_last_msg", mem_cmd_o, 16'hA002);
    tick();
    mem_resp_v_i = 1'b0;
    #1;
    chk("rr_idle", idle_o, 1'b1);
    chk("rr_err", error_o, 1'b0);

    // Credit limit on requester 1.
    do_reset();
    req_cmd_v_i = 3'b010;
    #1; chk("cr_g0", req_cmd_yumi_o, 3'b010); tick();
    #1; chk("cr_g1", req_cmd_yumi_o, 3'b010); tick();
    #1; chk("cr_blk0", req_cmd_yumi_o, 3'b000); tick();
    #1; chk("cr_blk1", req_cmd_yumi_o, 3'b000);
    chk("cr_idle", idle_o, 1'b0);
    tick();
    mem_resp_v_i = 1'b1; mem_resp_id_i = 3'd1; req_resp_yumi_i = 3'b010;
    #1;
    chk("cr_rspv", req_resp_v_o, 3'b010);
    chk("cr_rspy", mem_resp_yumi_o, 1'b1);
    chk("cr_blk2", req_cmd_yumi_o, 3'b000);
    tick();
    mem_resp_v_i = 1'b0; req_resp_yumi_i = '0;
    #1; chk("cr_regrant", req_cmd_yumi_o, 3'b010); tick();
    #1; chk("cr_blk3", req_cmd_yumi_o, 3'b000);

    // Backpressure: buffer holds while ready is low, then dequeue+grant together.
    do_reset();
    req_cmd_v_i = 3'b001; mem_cmd_ready_i = 1'b0;
    #1; chk("bp_g0", req_cmd_yumi_o, 3'b001); tick();
    req_cmd_v_i = 3'b010;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_hold_y%0d", k), req_cmd_yumi_o, 3'b000);
      chk($sformatf("bp_hold_v%0d", k), mem_cmd_v_o, 1'b1);
      chk($sformatf("bp_hold_m%0d", k), mem_cmd_o, 16'hA000);
      tick();
    end
    mem_cmd_ready_i = 1'b1;
    #1; chk("bp_rel_y", req_cmd_yumi_o, 3'b010); tick();
    req_cmd_v_i = '0;
    #1;
    chk("bp_next_v", mem_cmd_v_o, 1'b1);
    chk("bp_next_m", mem_cmd_o, 16'hA001);

    // Grant and response yumi to requester 2 in one cycle keep cnt[2] at 1.
    do_reset();
    req_cmd_v_i = 3'b100;
    #1; chk("sim_g0", req_cmd_yumi_o, 3'b100); tick();
    mem_resp_v_i = 1'b1; mem_resp_id_i = 3'd2; req_resp_yumi_i = 3'b100;
    #1;
    chk("sim_g1", req_cmd_yumi_o, 3'b100);
    chk("sim_rspy", mem_resp_yumi_o, 1'b1);
    tick();
    mem_resp_v_i = 1'b0; req_resp_yumi_i = '0;
    #1; chk("sim_g2", req_cmd_yumi_o, 3'b100); tick();
    #1; chk("sim_blk", req_cmd_yumi_o, 3'b000);

    // Response to a requester with nothing outstanding.
    do_reset();
    mem_resp_v_i = 1'b1; mem_resp_id_i = 3'd1;
    #1;
    chk("z_rspy", mem_resp_yumi_o, 1'b1);
    chk("z_rspv", req_resp_v_o, 3'b000);
    tick();
    mem_resp_v_i = 1'b0;
    #1; chk("z_err", error_o, 1'b1);

    // Out-of-range id.
    do_reset();
    #1; chk("inv_err_clr", error_o, 1'b0);
    mem_resp_v_i = 1'b1; mem_resp_id_i = 3'd5;
    #1;
    chk("inv_rspy", mem_resp_yumi_o, 1'b1);
    chk("inv_rspv", req_resp_v_o, 3'b000);
    chk("inv_err0", error_o, 1'b0);
    tick();
    mem_resp_v_i = 1'b0;
    #1; chk("inv_err1", error_o, 1'b1); tick(); tick();
    #1; chk("inv_err_sticky", error_o, 1'b1);
    chk("inv_idle", idle_o, 1'b1);

    // Mid-operation reset with cnt[1]=2, cnt[2]=1 and a buffered command.
    do_reset();
    req_cmd_v_i = 3'b010; #1; chk("mr_g1a", req_cmd_yumi_o, 3'b010); tick();
    req_cmd_v_i = 3'b100; #1; chk("mr_g2", req_cmd_yumi_o, 3'b100); tick();
    req_cmd_v_i = 3'b010; #1; chk("mr_g1b", req_cmd_yumi_o, 3'b010); tick();
    req_cmd_v_i = 3'b101; mem_cmd_ready_i = 1'b0;
    mem_resp_v_i = 1'b1; mem_resp_id_i = 3'd1; req_resp_yumi_i = 3'b010;
    #1;
    chk("mr_pre_v", mem_cmd_v_o, 1'b1);
    chk("mr_pre_idle", idle_o, 1'b0);
    reset_i = 1'b1;
    #1;
    chk("mr_rst_y", req_cmd_yumi_o, 3'b000);
    chk("mr_rst_v", mem_cmd_v_o, 1'b0);
    chk("mr_rst_ry", mem_resp_yumi_o, 1'b0);
    chk("mr_rst_rv", req_resp_v_o, 3'b000);
    chk("mr_rst_idle", idle_o, 1'b1);
    chk("mr_rst_err", error_o, 1'b0);
    tick();
    reset_i = 1'b0; mem_resp_v_i = 1'b0; req_resp_yumi_i = '0; mem_cmd_ready_i = 1'b1;
    #1; chk("mr_first", req_cmd_yumi_o, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
